// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the mul/div reservation station and dispatcher.
package tomasulo_pkg;

  localparam int unsigned DEPTH = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned TW    = 3;
  localparam int unsigned FW    = 4;
  localparam int unsigned RW    = 4;
  localparam int unsigned IW    = 3;
  localparam int unsigned SW    = 2;
  localparam int unsigned CW    = 2;

  localparam logic [FW-1:0] FUNC_MUL = 4'b0010;
  localparam logic [FW-1:0] FUNC_DIV = 4'b0011;

  typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} rs_state_t;

  // Operand slot 0 is rs1, slot 1 is rs2.
  typedef struct packed {
    logic [FW-1:0]          func;
    logic [RW-1:0]          rd;
    logic [TW-1:0]          rob;
    logic [1:0]             rdy;
    logic [1:0][TW-1:0]     tag;
    logic [1:0][DW-1:0]     data;
    rs_state_t              state;
  } rs_entry_t;

  typedef struct packed {
    logic [IW-1:0] index;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [FW-1:0] func;
    logic [TW-1:0] rob;
    logic [RW-1:0] rd;
  } disp_payload_t;

  function automatic logic func_legal(input logic [FW-1:0] f);
    return (f == FUNC_MUL) || (f == FUNC_DIV);
  endfunction

endpackage

// File: rtl/mul_rs_age_select.sv
// Age matrix over RS slots plus an oldest-ready picker.
module mul_rs_age_select
  import tomasulo_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  input  logic [SW-1:0]    alloc_idx,
  input  logic             free_valid,
  input  logic [SW-1:0]    free_idx,
  input  logic [DEPTH-1:0] ready_mask,
  output logic             pick_valid_c,
  output logic [SW-1:0]    pick_idx_c
);

  // older_q[i][j] set means slot i was issued before slot j.
  logic [DEPTH-1:0][DEPTH-1:0] older_q;
  logic [DEPTH-1:0][DEPTH-1:0] older_d;
  logic [DEPTH-1:0]            pick_c;

  always_comb begin
    older_d = older_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (i == j) begin
          older_d[i][j] = 1'b0;
        end else if (free_valid && (SW'(i) == free_idx || SW'(j) == free_idx)) begin
          older_d[i][j] = 1'b0;
        end else if (alloc_valid && SW'(i) == alloc_idx) begin
          older_d[i][j] = 1'b0;
        end else if (alloc_valid && SW'(j) == alloc_idx) begin
          older_d[i][j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) older_q <= '0;
    else        older_q <= older_d;
  end

  // A ready slot wins if it is older than every other ready slot.
  always_comb begin
    pick_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      pick_c[i] = ready_mask[i];
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (j != i && ready_mask[j] && !older_q[i][j]) pick_c[i] = 1'b0;
      end
    end
    pick_valid_c = |pick_c;
    pick_idx_c   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (pick_c[i]) pick_idx_c = SW'(i);
    end
  end

endmodule

// File: rtl/mul_rs_dispatch.sv
// Mul/div reservation station: issue, CDB operand capture, oldest-ready dispatch
// to a non-pipelined exec unit, and completion-driven release.
module mul_rs_dispatch
  import tomasulo_pkg::*;
(
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [FW-1:0] iss_func,
  input  logic [RW-1:0] iss_rd,
  input  logic [TW-1:0] iss_rob,
  input  logic          iss_rs1_rdy,
  input  logic          iss_rs2_rdy,
  input  logic [DW-1:0] iss_rs1_data,
  input  logic [DW-1:0] iss_rs2_data,
  input  logic [TW-1:0] iss_rs1_tag,
  input  logic [TW-1:0] iss_rs2_tag,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_rob,
  input  logic [DW-1:0] cdb_data,
  input  logic          ex_ready,
  input  logic          ex_done,
  input  logic [IW-1:0] ex_done_index,
  output logic          disp_valid,
  output logic [IW-1:0] rs_index,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic [FW-1:0] func,
  output logic [TW-1:0] rob_ind,
  output logic [RW-1:0] rd,
  output logic [CW-1:0] mul_count,
  output logic          err_func
);

  rs_entry_t [DEPTH-1:0] ent_q, ent_d;
  rs_entry_t             new_entry;
  rs_entry_t             sel_entry;
  disp_payload_t         pay_q, pay_d;
  logic                  disp_valid_d, inflight_q, inflight_d;
  logic [CW-1:0]         count_d;
  logic                  iss_ready_d, err_d;

  logic                  legal, accept, alloc_any, fire, done_ok;
  logic [SW-1:0]         alloc_slot, done_slot, pick_slot;
  logic [DEPTH-1:0]      ready_mask;
  logic                  pick_valid;

  assign legal     = func_legal(iss_func);
  assign accept    = iss_valid && iss_ready && alloc_any && legal;
  assign fire      = disp_valid && ex_ready;
  assign done_slot = ex_done_index[SW-1:0];

  // Lowest-index free slot, and validity of the completion index.
  always_comb begin
    alloc_any  = 1'b0;
    alloc_slot = '0;
    done_ok    = 1'b0;
    ready_mask = '0;
    sel_entry  = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (ent_q[i].state == FREE) begin
        alloc_any  = 1'b1;
        alloc_slot = SW'(i);
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ex_done && inflight_q && ex_done_index == IW'(i) && ent_q[i].state == EXEC)
        done_ok = 1'b1;
      ready_mask[i] = (ent_q[i].state == READY);
      if (pick_slot == SW'(i)) sel_entry = ent_q[i];
    end
  end

  // New entry, including same-cycle CDB bypass into a pending operand.
  always_comb begin
    new_entry         = '0;
    new_entry.func    = iss_func;
    new_entry.rd      = iss_rd;
    new_entry.rob     = iss_rob;
    new_entry.rdy     = {iss_rs2_rdy, iss_rs1_rdy};
    new_entry.tag[0]  = iss_rs1_tag;
    new_entry.tag[1]  = iss_rs2_tag;
    new_entry.data[0] = iss_rs1_data;
    new_entry.data[1] = iss_rs2_data;
    for (int k = 0; k < 2; k++) begin
      if (!new_entry.rdy[k] && cdb_valid && new_entry.tag[k] == cdb_rob) begin
        new_entry.rdy[k]  = 1'b1;
        new_entry.data[k] = cdb_data;
      end
    end
    new_entry.state = (&new_entry.rdy) ? READY : WAIT;
  end

  // Per-entry state machine.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      case (ent_q[i].state)
        FREE: if (accept && alloc_slot == SW'(i)) ent_d[i] = new_entry;
        WAIT: begin
          for (int k = 0; k < 2; k++) begin
            if (!ent_q[i].rdy[k] && cdb_valid && ent_q[i].tag[k] == cdb_rob) begin
              ent_d[i].rdy[k]  = 1'b1;
              ent_d[i].data[k] = cdb_data;
            end
          end
          if (&ent_d[i].rdy) ent_d[i].state = READY;
        end
        READY: if (fire && pay_q.index == IW'(i)) ent_d[i].state = EXEC;
        EXEC:  if (done_ok && done_slot == SW'(i)) ent_d[i] = '0;
        default: ent_d[i] = ent_q[i];
      endcase
    end
  end

  // Dispatch handshake, in-flight tracking, occupancy and error pulse.
  always_comb begin
    disp_valid_d = disp_valid;
    inflight_d   = inflight_q;
    pay_d        = pay_q;
    if (fire) begin
      disp_valid_d = 1'b0;
      inflight_d   = 1'b1;
    end else if (!disp_valid && !inflight_q && pick_valid) begin
      disp_valid_d   = 1'b1;
      pay_d.index    = IW'(pick_slot);
      pay_d.rs1_data = sel_entry.data[0];
      pay_d.rs2_data = sel_entry.data[1];
      pay_d.func     = sel_entry.func;
      pay_d.rob      = sel_entry.rob;
      pay_d.rd       = sel_entry.rd;
    end
    if (done_ok) inflight_d = 1'b0;

    case ({accept, done_ok})
      2'b10:   count_d = mul_count + CW'(1);
      2'b01:   count_d = mul_count - CW'(1);
      default: count_d = mul_count;
    endcase
    iss_ready_d = (count_d < CW'(DEPTH));
    err_d       = iss_valid && iss_ready && !legal;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      ent_q      <= '0;
      disp_valid <= 1'b0;
      inflight_q <= 1'b0;
      pay_q      <= '0;
      mul_count  <= '0;
      iss_ready  <= 1'b1;
      err_func   <= 1'b0;
    end else begin
      ent_q      <= ent_d;
      disp_valid <= disp_valid_d;
      inflight_q <= inflight_d;
      pay_q      <= pay_d;
      mul_count  <= count_d;
      iss_ready  <= iss_ready_d;
      err_func   <= err_d;
    end
  end

  assign rs_index = pay_q.index;
  assign rs1_data = pay_q.rs1_data;
  assign rs2_data = pay_q.rs2_data;
  assign func     = pay_q.func;
  assign rob_ind  = pay_q.rob;
  assign rd       = pay_q.rd;

  mul_rs_age_select u_age (
    .clk          (clk1),
    .rst_n        (rst_n),
    .alloc_valid  (accept),
    .alloc_idx    (alloc_slot),
    .free_valid   (done_ok),
    .free_idx     (done_slot),
    .ready_mask   (ready_mask),
    .pick_valid_c (pick_valid),
    .pick_idx_c   (pick_slot)
  );

endmodule

// File: tb/tb_mul_rs_dispatch.sv
// Scoreboard bench for mul_rs_dispatch: directed issues push expected dispatches,
// a monitor pops and compares on every handshake fire.
module tb_mul_rs_dispatch;
  import tomasulo_pkg::*;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          iss_valid = 1'b0, iss_ready;
  logic [3:0]    iss_func = '0, iss_rd = '0;
  logic [2:0]    iss_rob = '0, iss_rs1_tag = '0, iss_rs2_tag = '0;
  logic          iss_rs1_rdy = 1'b0, iss_rs2_rdy = 1'b0;
  logic [7:0]    iss_rs1_data = '0, iss_rs2_data = '0;
  logic          cdb_valid = 1'b0;
  logic [2:0]    cdb_rob = '0;
  logic [7:0]    cdb_data = '0;
  logic          ex_ready = 1'b0, ex_done = 1'b0;
  logic [2:0]    ex_done_index = '0;
  logic          disp_valid, err_func;
  logic [2:0]    rs_index, rob_ind;
  logic [7:0]    rs1_data, rs2_data;
  logic [3:0]    func, rd;
  logic [1:0]    mul_count;

  mul_rs_dispatch dut (
    .clk1(clk1), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func), .iss_rd(iss_rd),
    .iss_rob(iss_rob), .iss_rs1_rdy(iss_rs1_rdy), .iss_rs2_rdy(iss_rs2_rdy),
    .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data),
    .iss_rs1_tag(iss_rs1_tag), .iss_rs2_tag(iss_rs2_tag),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
    .ex_ready(ex_ready), .ex_done(ex_done), .ex_done_index(ex_done_index),
    .disp_valid(disp_valid), .rs_index(rs_index), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .func(func), .rob_ind(rob_ind), .rd(rd), .mul_count(mul_count), .err_func(err_func)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [3:0] fn;
    logic [2:0] rob;
    logic [3:0] rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   check_cnt = 0;
  int   pass_cnt  = 0;
  int   fire_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic expect_disp(input logic [2:0] idx, input logic [7:0] d1, input logic [7:0] d2,
                             input logic [3:0] fn, input logic [2:0] rob, input logic [3:0] r);
    exp_t e;
    e.idx = idx; e.d1 = d1; e.d2 = d2; e.fn = fn; e.rob = rob; e.rd = r;
    exp_q.push_back(e);
  endtask

  // Holds one issue request for one cycle; returns at the next falling edge.
  task automatic issue(input logic [3:0] f, input logic [3:0] r, input logic [2:0] rob,
                       input logic r1, input logic [7:0] d1, input logic [2:0] t1,
                       input logic r2, input logic [7:0] d2, input logic [2:0] t2);
    iss_valid = 1'b1; iss_func = f; iss_rd = r; iss_rob = rob;
    iss_rs1_rdy = r1; iss_rs1_data = d1; iss_rs1_tag = t1;
    iss_rs2_rdy = r2; iss_rs2_data = d2; iss_rs2_tag = t2;
    @(negedge clk1);
    iss_valid = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [7:0] d);
    cdb_valid = 1'b1; cdb_rob = tag; cdb_data = d;
    @(negedge clk1);
    cdb_valid = 1'b0;
  endtask

  task automatic wait_fire(input int n);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk1);
      cyc++;
    end while (fire_cnt < n && cyc < 200);
    if (fire_cnt < n) begin
      check_cnt++;
      $display("FAIL wait_fire: fires %0d expected %0d", fire_cnt, n);
    end
  endtask

  task automatic do_done(input logic [2:0] idx);
    ex_done = 1'b1; ex_done_index = idx;
    @(negedge clk1);
    ex_done = 1'b0;
  endtask

  // Monitor: a fire happens at the next rising edge when both are high here.
  always @(negedge clk1) begin
    #1;
    if (disp_valid && ex_ready) begin
      fire_cnt++;
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL dispatch: unexpected idx=%0d d1=%0h d2=%0h", rs_index, rs1_data, rs2_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rs_index === mon_e.idx && rs1_data === mon_e.d1 && rs2_data === mon_e.d2 &&
            func === mon_e.fn && rob_ind === mon_e.rob && rd === mon_e.rd)
          pass_cnt++;
        else
          $display("FAIL dispatch: got idx=%0d d1=%0h d2=%0h fn=%0h rob=%0d rd=%0d expected idx=%0d d1=%0h d2=%0h fn=%0h rob=%0d rd=%0d",
                   rs_index, rs1_data, rs2_data, func, rob_ind, rd,
                   mon_e.idx, mon_e.d1, mon_e.d2, mon_e.fn, mon_e.rob, mon_e.rd);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk1);
    check("rst_disp_valid", 32'(disp_valid), 0);
    check("rst_mul_count", 32'(mul_count), 0);
    check("rst_err_func", 32'(err_func), 0);
    check("rst_payload", {rs_index, rs1_data, rs2_data, func, rob_ind, rd}, 0);
    check("rst_iss_ready", 32'(iss_ready), 1);
    rst_n = 1'b1;
    @(negedge clk1);

    // Basic MUL with both operands ready.
    ex_ready = 1'b1;
    expect_disp(0, 8'd7, 8'd6, FUNC_MUL, 3'd2, 4'd5);
    issue(FUNC_MUL, 4'd5, 3'd2, 1'b1, 8'd7, 3'd0, 1'b1, 8'd6, 3'd0);
    check("t1_count_after_issue", 32'(mul_count), 1);
    check("t1_disp_latency_low", 32'(disp_valid), 0);
    @(negedge clk1);
    check("t1_disp_latency_high", 32'(disp_valid), 1);
    wait_fire(1);
    check("t1_disp_drops", 32'(disp_valid), 0);
    do_done(3'd0);
    check("t1_count_after_done", 32'(mul_count), 0);

    // DIV waiting on rs2 tag 4; a non-matching broadcast must not wake it.
    expect_disp(0, 8'd9, 8'd3, FUNC_DIV, 3'd5, 4'd3);
    issue(FUNC_DIV, 4'd3, 3'd5, 1'b1, 8'd9, 3'd0, 1'b0, 8'd0, 3'd4);
    cdb(3'd6, 8'h55);
    repeat (2) @(negedge clk1);
    check("t2_no_wake_wrong_tag", 32'(disp_valid), 0);
    cdb(3'd4, 8'd3);
    wait_fire(2);
    do_done(3'd0);

    // Same-cycle CDB bypass at issue.
    expect_disp(0, 8'd9, 8'd3, FUNC_DIV, 3'd6, 4'd4);
    cdb_valid = 1'b1; cdb_rob = 3'd4; cdb_data = 8'd3;
    issue(FUNC_DIV, 4'd4, 3'd6, 1'b1, 8'd9, 3'd0, 1'b0, 8'd0, 3'd4);
    cdb_valid = 1'b0;
    wait_fire(3);
    do_done(3'd0);

    // Both operands waiting on the same producer.
    expect_disp(0, 8'h0A, 8'h0A, FUNC_MUL, 3'd7, 4'd1);
    issue(FUNC_MUL, 4'd1, 3'd7, 1'b0, 8'd0, 3'd1, 1'b0, 8'd0, 3'd1);
    cdb(3'd1, 8'h0A);
    wait_fire(4);
    do_done(3'd0);
    check("t2_count_empty", 32'(mul_count), 0);

    // Fill all slots; free slot 1 while a 4th issue is pending.
    expect_disp(1, 8'd3, 8'd4, FUNC_DIV, 3'd2, 4'd2);
    issue(FUNC_MUL, 4'd1, 3'd1, 1'b0, 8'd0, 3'd7, 1'b1, 8'd2, 3'd0);
    issue(FUNC_DIV, 4'd2, 3'd2, 1'b1, 8'd3, 3'd0, 1'b1, 8'd4, 3'd0);
    issue(FUNC_DIV, 4'd3, 3'd3, 1'b1, 8'd5, 3'd0, 1'b0, 8'd0, 3'd7);
    check("t3_full_count", 32'(mul_count), 3);
    check("t3_full_not_ready", 32'(iss_ready), 0);
    wait_fire(5);
    expect_disp(1, 8'h21, 8'h22, FUNC_MUL, 3'd4, 4'd4);
    ex_done = 1'b1; ex_done_index = 3'd1;
    iss_valid = 1'b1; iss_func = FUNC_MUL; iss_rd = 4'd4; iss_rob = 3'd4;
    iss_rs1_rdy = 1'b1; iss_rs1_data = 8'h21; iss_rs2_rdy = 1'b1; iss_rs2_data = 8'h22;
    @(negedge clk1);
    ex_done = 1'b0;
    check("t3_ready_after_free", 32'(iss_ready), 1);
    @(negedge clk1);
    iss_valid = 1'b0;
    check("t3_refill_count", 32'(mul_count), 3);
    check("t3_refill_not_ready", 32'(iss_ready), 0);
    wait_fire(6);
    do_done(3'd1);
    // Slots 0 and 2 wake together; slot 0 is older.
    expect_disp(0, 8'h11, 8'd2, FUNC_MUL, 3'd1, 4'd1);
    expect_disp(2, 8'd5, 8'h11, FUNC_DIV, 3'd3, 4'd3);
    cdb(3'd7, 8'h11);
    wait_fire(7);
    do_done(3'd0);
    wait_fire(8);
    do_done(3'd2);
    check("t3_count_empty", 32'(mul_count), 0);

    // Exec unit stalled: payload must hold on slot 0.
    ex_ready = 1'b0;
    expect_disp(0, 8'd1, 8'd1, FUNC_MUL, 3'd1, 4'd1);
    expect_disp(2, 8'd3, 8'd3, FUNC_DIV, 3'd3, 4'd3);
    expect_disp(1, 8'h44, 8'd2, FUNC_MUL, 3'd2, 4'd2);
    issue(FUNC_MUL, 4'd1, 3'd1, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
    issue(FUNC_MUL, 4'd2, 3'd2, 1'b0, 8'd0, 3'd5, 1'b1, 8'd2, 3'd0);
    issue(FUNC_DIV, 4'd3, 3'd3, 1'b1, 8'd3, 3'd0, 1'b1, 8'd3, 3'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk1);
      check("t4_stall_valid", 32'(disp_valid), 1);
      check("t4_stall_payload", {rs_index, rs1_data, rs2_data}, {3'd0, 8'd1, 8'd1});
    end
    ex_ready = 1'b1;
    wait_fire(9);
    do_done(3'd0);
    wait_fire(10);
    do_done(3'd2);
    cdb(3'd5, 8'h44);
    wait_fire(11);
    do_done(3'd1);

    // Illegal function code.
    issue(4'b0101, 4'd9, 3'd1, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
    check("t5_err_pulse", 32'(err_func), 1);
    check("t5_err_count", 32'(mul_count), 0);
    @(negedge clk1);
    check("t5_err_clears", 32'(err_func), 0);
    check("t5_no_dispatch", 32'(disp_valid), 0);

    // Reset while an op is executing, then a stale completion.
    expect_disp(0, 8'd5, 8'd6, FUNC_MUL, 3'd3, 4'd2);
    issue(FUNC_MUL, 4'd2, 3'd3, 1'b1, 8'd5, 3'd0, 1'b1, 8'd6, 3'd0);
    wait_fire(12);
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", 32'(mul_count), 0);
    check("t6_rst_payload", {disp_valid, rs_index, rs1_data, rs2_data, func, rob_ind, rd}, 0);
    @(negedge clk1);
    rst_n = 1'b1;
    do_done(3'd0);
    check("t6_late_done_count", 32'(mul_count), 0);
    check("t6_late_done_ready", 32'(iss_ready), 1);
    repeat (3) @(negedge clk1);
    check("t6_no_redispatch", 32'(disp_valid), 0);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/mul_rs_dispatch.md
Name: mul_rs_dispatch

Overview:
- Multiply/divide reservation station and dispatcher: the transmit side of the mul/div execution-unit dispatch interface.
- Holds up to 3 issued MUL/DIV ops and captures operands from the common data bus (CDB).
- Selects the oldest ready entry and presents it to the mul/div exec unit with a valid/ready handshake.
- Frees the entry only when the exec unit reports completion; sits between the issue stage and exec unit 3.

Parameters:
- DEPTH, 3, number of RS entries (index width 3 bits, fixed).
- DW, 8, operand data width.
- TW, 3, ROB tag width.

Ports:
- clk1  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  issue request.
- iss_ready  out  1  entry available (count < DEPTH).
- iss_func  in  4  0010 = MUL, 0011 = DIV.
- iss_rd  in  4  destination register.
- iss_rob  in  TW  ROB index of this op.
- iss_rs1_rdy / iss_rs2_rdy  in  1 each  operand value valid at issue.
- iss_rs1_data / iss_rs2_data  in  DW each  operand value.
- iss_rs1_tag / iss_rs2_tag  in  TW each  producer ROB tag when not ready.
- cdb_valid  in  1  result broadcast valid.
- cdb_rob  in  TW  ROB tag of broadcast.
- cdb_data  in  DW  broadcast value (low 8 bits).
- ex_ready  in  1  exec unit idle, accepts dispatch.
- ex_done  in  1  one-cycle completion pulse.
- ex_done_index  in  3  RS index being completed.
- disp_valid  out  1  dispatch request.
- rs_index, rs1_data, rs2_data, func, rob_ind, rd  out  3/DW/DW/4/TW/4  dispatch payload.
- mul_count  out  2  occupied entries.
- err_func  out  1  one-cycle pulse on an illegal func.

Behaviour:
- Reset (async, rst_n=0): all entries FREE; disp_valid=0; payload outputs 0; mul_count=0; err_func=0; in-flight flag cleared; age state cleared.
- Per-entry states:
  - FREE -> WAIT on issue with an operand outstanding; FREE -> READY on issue with both operands ready.
  - WAIT -> READY when the last outstanding tag matches the CDB.
  - READY -> EXEC on a handshake fire (disp_valid && ex_ready).
  - EXEC -> FREE on ex_done with ex_done_index == entry.
- Issue:
  - Accept when iss_valid && iss_ready. Allocate the lowest-index FREE entry; the op is registered by the next edge.
  - iss_ready is derived from registered state only, so a slot freed by ex_done is usable the following cycle.
  - Illegal func (neither 0010 nor 0011): op dropped, no allocation, err_func pulses 1 cycle.
- CDB capture:
  - Each cycle, every WAIT entry compares both pending tags to cdb_rob when cdb_valid; a match latches cdb_data and sets that operand ready.
  - Same-cycle bypass: if the CDB tag equals an issuing operand's tag, capture cdb_data into the new entry directly.
  - Both operands matching the same broadcast become ready together.
- Select: oldest READY entry by issue order (age matrix); ties cannot occur.
- Dispatch:
  - disp_valid is registered; it rises the cycle after some entry is READY and no op is in flight.
  - Payload is stable while disp_valid=1 && ex_ready=0.
  - On fire, disp_valid drops the next cycle and the in-flight flag sets. No further dispatch until the matching ex_done (non-pipelined unit, up to 60/80 cycles).
  - Same-cycle fire and ex_done cannot occur for the same entry.
  - ex_done with an index not in EXEC, or with no op in flight, is ignored.
- mul_count: increments on accepted issue, decrements on a valid ex_done. Simultaneous increment and decrement leaves it unchanged. Range 0..3, never wraps.
- Reset mid-operation: in-flight op abandoned; a late ex_done arriving after reset is ignored.

Decomposition:
- Shared package tomasulo_pkg:
  - FUNC_MUL=4'b0010, FUNC_DIV=4'b0011.
  - DW/TW widths.
  - rs_state_t enum {FREE, WAIT, READY, EXEC}.
  - rs_entry_t struct (func, rd, rob, rdy[2], tag[2], data[2], state).
- One sub-module: mul_rs_age_select — age-matrix update on allocate/free plus the oldest-ready one-hot picker.

Test Plan:
- Issue MUL rd=5, rob=2, ops 7 and 6 both ready, ex_ready=1 -> disp_valid=1 two cycles after issue with rs_index=0, rs1_data=7, rs2_data=6, func=0010, rob_ind=2. Then ex_done index 0 -> mul_count 1 -> 0.
- Issue DIV with rs2 waiting on tag 4, then CDB {rob=4, data=3} -> entry READY, dispatched with rs2_data=3. Repeat with the CDB in the issue cycle (bypass) -> same result.
- Fill 3 entries -> iss_ready=0 and a 4th issue is not accepted. ex_done index 1 and a new issue in the same cycle -> new op allocated to index 1 the following cycle, mul_count stays 3.
- Entries 0 (older) and 2 (newer) both READY with ex_ready=0 for 5 cycles -> payload held stable on entry 0. After ex_ready and ex_done, entry 2 dispatches next.
- Issue func=0101 -> err_func pulses once, mul_count stays 0. Assert rst_n=0 while an op is in EXEC, then ex_done -> all outputs 0 and ex_done ignored.
